sequence_pattern_generator: RTL and testbench
=============================================

// Module: sequence_pattern_generator
// PURPOSE
//  Serial stimulus source paired with the serial sequence detector. Loads a WIDTH-bit word and
//  shifts it out MSB-first on x, one bit per clk, feeding the detector's x input directly.
//  Supports one-shot frames or continuous circular rotation of the loaded word.
//  Accepts parallel words over a valid/ready handshake.
// PARAMETERS
//  WIDTH   20   frame length in bits; legal range WIDTH >= 2
//  CNT_W   $clog2(WIDTH)   localparam; width of the bit counter
// PORTS
//  clk         in   1      clock; all state updates on posedge
//  rst         in   1      asynchronous, active-low reset
//  load_valid  in   1      load_data is valid
//  load_ready  out  1      generator can accept a word
//  load_data   in   WIDTH  word to serialise; bit WIDTH-1 is sent first
//  circular    in   1      sampled at accept; 1 = repeat the word until stop
//  stop        in   1      sampled at the last bit of each frame; ends circular mode
//  x           out  1      serial data (the detector's x)
//  x_valid     out  1      x carries a frame bit this cycle
//  frame_done  out  1      high during the cycle the final bit of a frame is on x
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, shift reg=0, cnt=0, circ=0.
//   Outputs: x=0, x_valid=0, load_ready=1, frame_done=0.
//  x is the shift reg MSB taken directly from a flop, with no output combinational logic.
//  States: IDLE, SHIFT, plus PARITY when the parity macro is defined.
//  IDLE:
//   - load_ready=1, x_valid=0.
//   - Accept = load_valid & load_ready at posedge: sr<=load_data, circ<=circular, cnt<=0, ->SHIFT.
//  SHIFT:
//   - x_valid=1. Each posedge: sr<={sr[W-2:0],sr[W-1]} (rotate left), cnt<=cnt+1.
//   - Latency: load_data[W-1] appears on x the first cycle after accept; bit k appears on cycle k+1.
//   - Last bit (cnt==W-1), no parity: frame_done=1.
//     - If circ & !stop: cnt<=0 and stay in SHIFT. The rotated sr equals the original word, so there is no gap.
//     - Otherwise: load_ready=1 this cycle. An accept here reloads and stays in SHIFT (zero-gap back-to-back); no accept ->IDLE.
//   - load_ready=0 in every other SHIFT cycle; load_valid is ignored there, and data is neither lost nor latched.
//  stop asserted mid-frame: the current frame completes and stop is honoured only at the last bit.
//  circular changing after accept has no effect on the frame in progress.
//  Reset mid-frame aborts immediately. The partial frame is dropped.
// CONFIGURATION
//  SEQ_GEN_PARITY_EN defined:
//   - A PARITY state follows the last data bit. x = even parity (XOR of the frame word), x_valid=1.
//   - frame_done and the last-bit decisions above (circular loop or reload) move to the PARITY cycle. Frame = W+1 cycles.
//  Not defined: no PARITY state, no parity flop. Frame = W cycles exactly.
// STRUCTURE
//  Shared package seq_gen_pkg:
//   - state enum localparams IDLE/SHIFT/PARITY (2-bit encoding)
//   - default WIDTH constant, shared with the detector bench
//  Single flat module with no sub-modules; FSM, counter and shift reg are all inline.
// TESTING
//  1. Single frame: W=20, data 20'hC9094, circular=0.
//     -> x on cycles 1..20 = 1100_1001_0000_1001_0100. frame_done at cycle 20. IDLE with load_ready=1 at cycle 21.
//  2. Circular: same word, circular=1, stop pulsed at cycle 45.
//     -> pattern repeats with no gap. frame_done at cycles 20, 40, 60. x_valid drops at cycle 61.
//  3. Back-to-back: second word 20'hFFFFF offered at cycle 20 of frame 1.
//     -> accepted at cycle 20; x=1 from cycle 21 to cycle 40 with x_valid continuous.
//  4. Busy load: load_valid pulsed with 20'h00000 at cycle 7.
//     -> load_ready=0 and the output stream is unchanged.
//  5. Reset: rst=0 asserted at cycle 10 between clock edges.
//     -> x=0, x_valid=0, load_ready=1 immediately. After release the generator is in IDLE.
//  6. Parity (SEQ_GEN_PARITY_EN): word 20'hC9094 has 7 ones.
//     -> x=1 on cycle 21, frame_done at cycle 21. Loopback into the detector gives the expected z pulses.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// Package: seq_gen_pkg
// Shared definitions for the serial sequence pattern generator and the
// detector bench: FSM state encoding and the default frame width.
package seq_gen_pkg;

  // Default frame length in bits
  localparam int unsigned SEQ_GEN_WIDTH = 20;

  // Generator FSM states; PARITY is only reachable with SEQ_GEN_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } seq_gen_state_t;

endpackage : seq_gen_pkg

// File: rtl/sequence_pattern_generator.sv
// Module: sequence_pattern_generator
// Serialises a WIDTH-bit word MSB-first on x, one bit per clk, as one-shot
// frames or as a continuous rotation of the loaded word until stop.
// Words are accepted over a load_valid/load_ready handshake; a word offered
// on the last cycle of a frame is taken with no gap between frames.
//
// Optional feature macro: SEQ_GEN_PARITY_EN
//   defined   -> an even-parity bit follows each frame (frame = WIDTH+1 cycles)
//   undefined -> frame = WIDTH cycles, no parity state or flop
//
// Ports:
//   clk         in   1      clock, all state updates on posedge
//   rst         in   1      asynchronous active-low reset
//   load_valid  in   1      load_data is valid
//   load_ready  out  1      generator can accept a word this cycle
//   load_data   in   WIDTH  word to serialise, bit WIDTH-1 sent first
//   circular    in   1      sampled at accept, 1 = repeat word until stop
//   stop        in   1      ends circular mode at the end of the current frame
//   x           out  1      serial data
//   x_valid     out  1      x carries a frame bit this cycle
//   frame_done  out  1      final bit of a frame is on x this cycle
module sequence_pattern_generator
  import seq_gen_pkg::*;
#(
  parameter int unsigned WIDTH = SEQ_GEN_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             circular,
  input  logic             stop,
  output logic             x,
  output logic             x_valid,
  output logic             frame_done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  seq_gen_state_t   r_state;
  seq_gen_state_t   w_state_nxt;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_circ;
  logic             w_circ_nxt;
  logic             r_stop_pend;
  logic             w_stop_pend_nxt;
`ifdef SEQ_GEN_PARITY_EN
  logic             r_par;
  logic             w_par_nxt;
`endif

  logic w_last_bit;
  logic w_frame_end;
  logic w_stop_eff;
  logic w_loop;
  logic w_accept;

  // Frame boundary decode: the last data bit, or the parity bit when enabled
  assign w_last_bit = (r_state == SHIFT) && (r_cnt == LAST_CNT);
`ifdef SEQ_GEN_PARITY_EN
  assign w_frame_end = (r_state == PARITY);
`else
  assign w_frame_end = w_last_bit;
`endif

  // A stop seen mid-frame is remembered so it takes effect at the frame end
  assign w_stop_eff = stop | r_stop_pend;
  assign w_loop     = w_frame_end & r_circ & ~w_stop_eff;

  assign load_ready = (r_state == IDLE) | (w_frame_end & ~w_loop);
  assign w_accept   = load_valid & load_ready;
  assign x_valid    = (r_state != IDLE);
  assign frame_done = w_frame_end;

`ifdef SEQ_GEN_PARITY_EN
  assign x = (r_state == PARITY) ? r_par : r_sr[WIDTH-1];
`else
  assign x = r_sr[WIDTH-1];
`endif

  // Next-state logic; an accept overrides whatever the frame end decided
  always_comb begin
    w_state_nxt     = r_state;
    w_sr_nxt        = r_sr;
    w_cnt_nxt       = r_cnt;
    w_circ_nxt      = r_circ;
    w_stop_pend_nxt = r_stop_pend;
`ifdef SEQ_GEN_PARITY_EN
    w_par_nxt       = r_par;
`endif

    case (r_state)
      IDLE: begin
        w_stop_pend_nxt = 1'b0;
      end
      SHIFT: begin
        // Rotating (not shifting) leaves the original word after WIDTH steps
        w_sr_nxt  = {r_sr[WIDTH-2:0], r_sr[WIDTH-1]};
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (!w_frame_end && stop) begin
          w_stop_pend_nxt = 1'b1;
        end
`ifdef SEQ_GEN_PARITY_EN
        if (w_last_bit) begin
          w_state_nxt = PARITY;
        end
`else
        if (w_last_bit) begin
          w_stop_pend_nxt = 1'b0;
          w_cnt_nxt       = '0;
          if (!w_loop) begin
            w_state_nxt = IDLE;
          end
        end
`endif
      end
`ifdef SEQ_GEN_PARITY_EN
      PARITY: begin
        w_stop_pend_nxt = 1'b0;
        w_cnt_nxt       = '0;
        w_state_nxt     = w_loop ? SHIFT : IDLE;
      end
`endif
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (w_accept) begin
      w_state_nxt     = SHIFT;
      w_sr_nxt        = load_data;
      w_cnt_nxt       = '0;
      w_circ_nxt      = circular;
      w_stop_pend_nxt = 1'b0;
`ifdef SEQ_GEN_PARITY_EN
      w_par_nxt       = ^load_data;
`endif
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_sr        <= '0;
      r_cnt       <= '0;
      r_circ      <= 1'b0;
      r_stop_pend <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
      r_par       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_sr        <= w_sr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_circ      <= w_circ_nxt;
      r_stop_pend <= w_stop_pend_nxt;
`ifdef SEQ_GEN_PARITY_EN
      r_par       <= w_par_nxt;
`endif
    end
  end

endmodule : sequence_pattern_generator

// File: tb/tb_sequence_pattern_generator.sv
// Testbench: tb_sequence_pattern_generator
// Scoreboarded bench for sequence_pattern_generator. The driver keeps a
// frame-level model (bits remaining in the current frame, looping flag,
// pending stop) and pushes every expected serial bit into a queue when a
// frame starts; an independent monitor pops and compares whenever x_valid.
// Honours SEQ_GEN_PARITY_EN to match the RTL build.
module tb_sequence_pattern_generator;
  import seq_gen_pkg::*;

  localparam int unsigned W = SEQ_GEN_WIDTH;
`ifdef SEQ_GEN_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FLEN = int'(W) + (PAR ? 1 : 0);

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load_valid = 1'b0;
  logic         load_ready;
  logic [W-1:0] load_data = '0;
  logic         circular = 1'b0;
  logic         stop = 1'b0;
  logic         x;
  logic         x_valid;
  logic         frame_done;

  sequence_pattern_generator #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .circular   (circular),
    .stop       (stop),
    .x          (x),
    .x_valid    (x_valid),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic x;
    logic fd;
  } exp_t;

  exp_t         exp_q[$];
  int           total = 0;
  int           bad   = 0;

  // Frame-level reference state
  int           rem      = 0;
  logic [W-1:0] m_word   = '0;
  logic         m_circ   = 1'b0;
  logic         m_pend   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // A frame is the word MSB-first, optionally followed by its even parity
  task automatic push_frame(input logic [W-1:0] d);
    exp_t e;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      e.x  = d[i];
      e.fd = (i == 0) && !PAR;
      exp_q.push_back(e);
    end
    if (PAR) begin
      e.x  = ^d;
      e.fd = 1'b1;
      exp_q.push_back(e);
    end
    rem = FLEN;
  endtask

  // One clock of stimulus: drive at negedge, check handshake, update model at posedge
  task automatic cycle(input logic lv, input logic [W-1:0] d, input logic c, input logic s);
    logic m_ready;
    logic acc;
    logic last;
    @(negedge clk);
    load_valid = lv;
    load_data  = d;
    circular   = c;
    stop       = s;
    #1;
    m_ready = (rem == 0) || ((rem == 1) && !(m_circ && !(s || m_pend)));
    chk("load_ready", 32'(load_ready), 32'(m_ready));
    chk("x_valid", 32'(x_valid), 32'(rem > 0));
    acc = lv && m_ready;
    @(posedge clk);
    if (rem > 0) begin
      last = (rem == 1);
      rem--;
      if (last) begin
        if (m_circ && !(s || m_pend)) begin
          push_frame(m_word);
        end else if (acc) begin
          m_word = d;
          m_circ = c;
          push_frame(d);
        end
        m_pend = 1'b0;
      end else if (s) begin
        m_pend = 1'b1;
      end
    end else if (acc) begin
      m_word = d;
      m_circ = c;
      m_pend = 1'b0;
      push_frame(d);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted between clock edges
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_x", 32'(x), 32'(0));
    chk("rst_x_valid", 32'(x_valid), 32'(0));
    chk("rst_load_ready", 32'(load_ready), 32'(1));
    chk("rst_frame_done", 32'(frame_done), 32'(0));
    exp_q.delete();
    rem    = 0;
    m_pend = 1'b0;
    m_circ = 1'b0;
    load_valid = 1'b0;
    stop       = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Monitor: every valid output bit is matched against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst && x_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_bit: got x=%0b with empty queue at %0t", x, $time);
      end else begin
        e = exp_q.pop_front();
        chk("x", 32'(x), 32'(e.x));
        chk("frame_done", 32'(frame_done), 32'(e.fd));
      end
    end
  end

  initial begin
    #3;
    chk("init_x", 32'(x), 32'(0));
    chk("init_x_valid", 32'(x_valid), 32'(0));
    chk("init_load_ready", 32'(load_ready), 32'(1));
    chk("init_frame_done", 32'(frame_done), 32'(0));
    @(negedge clk);
    #1;
    rst = 1'b1;

    // Single one-shot frame
    cycle(1'b1, W'(20'hC9094), 1'b0, 1'b0);
    idle(FLEN + 3);

    // Circular with a stop pulse mid-frame in the third frame
    cycle(1'b1, W'(20'hC9094), 1'b1, 1'b0);
    for (int c = 1; c <= 3 * FLEN + 3; c++) begin
      cycle(1'b0, '0, 1'b0, c == 45);
    end

    // Back-to-back: second word offered on the final cycle of frame 1
    cycle(1'b1, W'(20'hC9094), 1'b0, 1'b0);
    idle(FLEN - 1);
    cycle(1'b1, W'(20'hFFFFF), 1'b0, 1'b0);
    idle(FLEN + 2);

    // Busy load attempt mid-frame is ignored
    cycle(1'b1, W'(20'h5A5A5), 1'b0, 1'b0);
    idle(5);
    cycle(1'b1, W'(20'h00000), 1'b1, 1'b0);
    idle(FLEN);

    // Reset mid-frame drops the partial frame
    cycle(1'b1, W'(20'hC9094), 1'b1, 1'b0);
    idle(9);
    do_reset();
    idle(3);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom % 3) == 0, W'($urandom), 1'($urandom), ($urandom % 12) == 0);
    end

    // Drain with stop held so any circular run terminates
    for (int i = 0; i < 2 * FLEN + 4; i++) cycle(1'b0, '0, 1'b0, 1'b1);
    idle(2);
    chk("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sequence_pattern_generator
